// File: rtl/pac_motion_pkg.sv
// Shared Pac-Man types: direction codes, screen geometry, FSM states and a
// position-step helper reused by ghost motion and the display stage.
package pac_motion_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE   = 32;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ_A = 3'd1,
        ST_REQ_B = 3'd2,
        ST_CUR_A = 3'd3,
        ST_CUR_B = 3'd4,
        ST_MOVE  = 3'd5
    } fsm_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } pos_t;

    // Caller guarantees the step stays on screen (bounds already checked).
    function automatic pos_t step_pos(input pos_t p, input logic [1:0] dir, input logic [8:0] step);
        pos_t n;
        n = p;
        case (dir)
            DIR_DOWN:  n.y = p.y + step;
            DIR_UP:    n.y = p.y - step;
            DIR_RIGHT: n.x = p.x + {1'b0, step};
            DIR_LEFT:  n.x = p.x - {1'b0, step};
            default:   n = p;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pac_probe_calc.sv
// Leading-edge corner probe for a sprite stepping one move in a direction.
// Flags out-of-bounds moves and then drives the probe at (0,0).
module pac_probe_calc
    import pac_motion_pkg::*;
#(
    parameter int STEP   = 2,
    parameter int SPRITE = 32,
    parameter int X_MAX  = 608,
    parameter int Y_MAX  = 448
) (
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic [1:0] i_dir,
    input  logic       i_sel,
    output logic [9:0] o_probe_x,
    output logic [8:0] o_probe_y,
    output logic       o_oob
);

    localparam logic [10:0] SX = 11'(STEP);
    localparam logic [10:0] LX = 11'(SPRITE - 1);
    localparam logic [10:0] XM = 11'(X_MAX);
    localparam logic [9:0]  SY = 10'(STEP);
    localparam logic [9:0]  LY = 10'(SPRITE - 1);
    localparam logic [9:0]  YM = 10'(Y_MAX);

    logic [10:0] w_xe;
    logic [9:0]  w_ye;
    logic [10:0] w_off_x;
    logic [9:0]  w_off_y;
    logic [10:0] w_px;
    logic [9:0]  w_py;
    logic        w_oob;
    logic        w_bad;

    // Corner coordinates in widened arithmetic so the bound tests cannot wrap.
    always_comb begin
        w_xe    = {1'b0, i_x};
        w_ye    = {1'b0, i_y};
        w_off_x = i_sel ? LX : 11'd0;
        w_off_y = i_sel ? LY : 10'd0;
        w_px    = 11'd0;
        w_py    = 10'd0;
        w_oob   = 1'b0;
        case (i_dir)
            DIR_DOWN: begin
                w_oob = (w_ye + SY) > YM;
                w_px  = w_xe + w_off_x;
                w_py  = w_ye + SY + LY;
            end
            DIR_UP: begin
                w_oob = w_ye < SY;
                w_px  = w_xe + w_off_x;
                w_py  = w_ye - SY;
            end
            DIR_RIGHT: begin
                w_oob = (w_xe + SX) > XM;
                w_px  = w_xe + SX + LX;
                w_py  = w_ye + w_off_y;
            end
            DIR_LEFT: begin
                w_oob = w_xe < SX;
                w_px  = w_xe - SX;
                w_py  = w_ye + w_off_y;
            end
            default: begin
                w_oob = 1'b1;
            end
        endcase
        w_bad = w_oob | w_px[10] | w_py[9];
        if (w_bad) begin
            o_probe_x = 10'd0;
            o_probe_y = 9'd0;
        end else begin
            o_probe_x = w_px[9:0];
            o_probe_y = w_py[8:0];
        end
        o_oob = w_bad;
    end

endmodule

// File: rtl/pac_motion.sv
// Pac-Man sprite motion: per frame tick, try the requested direction, fall
// back to the current heading, and step only if the wall map is clear.
module pac_motion
    import pac_motion_pkg::*;
#(
    parameter int STEP    = 2,
    parameter int SPRITE  = 32,
    parameter int START_X = 304,
    parameter int START_Y = 224,
    parameter int X_MAX   = 608,
    parameter int Y_MAX   = 448
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       over,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    output logic [9:0] probe_x,
    output logic [8:0] probe_y,
    input  logic       probe_wall,
    output logic [9:0] PacX,
    output logic [8:0] PacY,
    output logic [1:0] state,
    output logic       busy,
    output logic       moved
);

    fsm_t       r_fsm;
    logic [9:0] r_pac_x;
    logic [8:0] r_pac_y;
    logic [1:0] r_state;
    logic [1:0] r_pend;
    logic [1:0] r_eval_dir;
    logic [1:0] r_move_dir;
    logic       r_req_hit;
    logic       r_cur_hit;
    logic       r_busy;
    logic       r_moved;

    logic [1:0] w_probe_dir;
    logic       w_probe_sel;
    logic       w_probing;
    logic [9:0] w_calc_x;
    logic [8:0] w_calc_y;
    logic       w_calc_oob;
    logic       w_hit;
    pos_t       w_cur_pos;
    pos_t       w_next_pos;

    // Select which candidate direction and corner the wall map is asked about.
    always_comb begin
        w_probe_dir = r_state;
        w_probe_sel = 1'b0;
        w_probing   = 1'b0;
        case (r_fsm)
            ST_REQ_A: begin
                w_probe_dir = r_eval_dir;
                w_probing   = 1'b1;
            end
            ST_REQ_B: begin
                w_probe_dir = r_eval_dir;
                w_probe_sel = 1'b1;
                w_probing   = 1'b1;
            end
            ST_CUR_A: begin
                w_probing   = 1'b1;
            end
            ST_CUR_B: begin
                w_probe_sel = 1'b1;
                w_probing   = 1'b1;
            end
            default: begin
                w_probing   = 1'b0;
            end
        endcase
    end

    pac_probe_calc #(
        .STEP   (STEP),
        .SPRITE (SPRITE),
        .X_MAX  (X_MAX),
        .Y_MAX  (Y_MAX)
    ) u_probe (
        .i_x       (r_pac_x),
        .i_y       (r_pac_y),
        .i_dir     (w_probe_dir),
        .i_sel     (w_probe_sel),
        .o_probe_x (w_calc_x),
        .o_probe_y (w_calc_y),
        .o_oob     (w_calc_oob)
    );

    assign probe_x    = w_probing ? w_calc_x : 10'd0;
    assign probe_y    = w_probing ? w_calc_y : 9'd0;
    assign w_hit      = w_calc_oob | probe_wall;
    assign w_cur_pos  = {r_pac_x, r_pac_y};
    assign w_next_pos = step_pos(w_cur_pos, r_move_dir, 9'(STEP));

    // Move-evaluation sequencer; every path takes a fixed number of cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm      <= ST_IDLE;
            r_pac_x    <= 10'(START_X);
            r_pac_y    <= 9'(START_Y);
            r_state    <= DIR_RIGHT;
            r_pend     <= DIR_RIGHT;
            r_eval_dir <= DIR_RIGHT;
            r_move_dir <= DIR_RIGHT;
            r_req_hit  <= 1'b0;
            r_cur_hit  <= 1'b0;
            r_busy     <= 1'b0;
            r_moved    <= 1'b0;
        end else begin
            if (dir_valid) begin
                r_pend <= dir_req;
            end
            r_moved <= 1'b0;
            case (r_fsm)
                ST_IDLE: begin
                    if (tick && !over) begin
                        r_eval_dir <= dir_valid ? dir_req : r_pend;
                        r_fsm      <= ST_REQ_A;
                        r_busy     <= 1'b1;
                    end
                end
                ST_REQ_A: begin
                    r_req_hit <= w_hit;
                    r_fsm     <= ST_REQ_B;
                end
                ST_REQ_B: begin
                    if (!(r_req_hit || w_hit)) begin
                        r_move_dir <= r_eval_dir;
                        r_fsm      <= ST_MOVE;
                    end else begin
                        r_fsm      <= ST_CUR_A;
                    end
                end
                ST_CUR_A: begin
                    r_cur_hit <= w_hit;
                    r_fsm     <= ST_CUR_B;
                end
                ST_CUR_B: begin
                    if (!(r_cur_hit || w_hit)) begin
                        r_move_dir <= r_state;
                        r_fsm      <= ST_MOVE;
                    end else begin
                        r_fsm      <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                ST_MOVE: begin
                    r_state <= r_move_dir;
                    r_pac_x <= w_next_pos.x;
                    r_pac_y <= w_next_pos.y;
                    r_moved <= 1'b1;
                    r_fsm   <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_fsm  <= ST_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign PacX  = r_pac_x;
    assign PacY  = r_pac_y;
    assign state = r_state;
    assign busy  = r_busy;
    assign moved = r_moved;

endmodule

// File: tb/tb_pac_motion.sv
// Self-checking bench for pac_motion: directed table, corner sequences and
// randomized ticks against a position/wall reference model.
module tb_pac_motion;

    logic       clk = 1'b0;
    logic       rst, tick, over, dir_valid;
    logic [1:0] dir_req;

    logic [9:0] px1, px0, x1, x0;
    logic [8:0] py1, py0, y1, y0;
    logic [1:0] st1, st0;
    logic       busy1, busy0, moved1, moved0, wall1, wall0;

    int map_mode = 0;
    bit use0 = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] w_x, w_px;
    logic [8:0] w_y, w_py;
    logic [1:0] w_st;
    logic       w_busy, w_moved;

    always #5 clk = ~clk;

    function automatic bit wall_at(input int mode, input int x, input int y);
        case (mode)
            1:       return (x >= 339) || (y >= 256);
            2:       return ((x + 3 * y) % 37) == 0;
            default: return 1'b0;
        endcase
    endfunction

    always_comb wall1 = wall_at(map_mode, int'(px1), int'(py1));
    always_comb wall0 = wall_at(map_mode, int'(px0), int'(py0));

    pac_motion u_dut (
        .clk(clk), .rst(rst), .tick(tick), .over(over), .dir_valid(dir_valid), .dir_req(dir_req),
        .probe_x(px1), .probe_y(py1), .probe_wall(wall1),
        .PacX(x1), .PacY(y1), .state(st1), .busy(busy1), .moved(moved1)
    );

    pac_motion #(.START_X(0)) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick), .over(over), .dir_valid(dir_valid), .dir_req(dir_req),
        .probe_x(px0), .probe_y(py0), .probe_wall(wall0),
        .PacX(x0), .PacY(y0), .state(st0), .busy(busy0), .moved(moved0)
    );

    assign w_x     = use0 ? x0 : x1;
    assign w_y     = use0 ? y0 : y1;
    assign w_st    = use0 ? st0 : st1;
    assign w_px    = use0 ? px0 : px1;
    assign w_py    = use0 ? py0 : py1;
    assign w_busy  = use0 ? busy0 : busy1;
    assign w_moved = use0 ? moved0 : moved1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: a direction is blocked by the screen edge or a wall at either leading corner.
    function automatic bit blocked(input int mode, input int x, input int y, input int d);
        case (d)
            0:       return (y + 2 > 448) || wall_at(mode, x, y + 33) || wall_at(mode, x + 31, y + 33);
            1:       return (y < 2) || wall_at(mode, x, y - 2) || wall_at(mode, x + 31, y - 2);
            2:       return (x + 2 > 608) || wall_at(mode, x + 33, y) || wall_at(mode, x + 33, y + 31);
            default: return (x < 2) || wall_at(mode, x - 2, y) || wall_at(mode, x - 2, y + 31);
        endcase
    endfunction

    task automatic do_reset();
        tick = 1'b0; dir_valid = 1'b0; dir_req = 2'b00; over = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One tick, then 7 sampled cycles: moved must pulse exactly at elat (0 = never).
    task automatic apply_tick(input bit v, input logic [1:0] r, input bit ov, input bit ev,
                              input logic [1:0] er, input int ex, input int ey, input int est,
                              input int elat, input bit chk_probe);
        over = ov; tick = 1'b1; dir_valid = v; dir_req = r;
        @(negedge clk);
        tick = 1'b0; dir_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) begin
                chk("busy_after_tick", int'(w_busy), ov ? 0 : 1);
                if (chk_probe) chk("probe_clamped", int'(w_px) + int'(w_py), 0);
            end
            chk($sformatf("moved_cycle%0d", k), int'(w_moved), (k == elat) ? 1 : 0);
            if (k == 2 && ev) begin
                tick = 1'b1; dir_valid = 1'b1; dir_req = er;
            end
            @(negedge clk);
            tick = 1'b0; dir_valid = 1'b0;
        end
        chk("busy_end", int'(w_busy), 0);
        chk("PacX", int'(w_x), ex);
        chk("PacY", int'(w_y), ey);
        chk("state", int'(w_st), est);
    endtask

    typedef struct {
        bit         rst_first;
        int         mode;
        bit         ov;
        bit         v;
        logic [1:0] r;
        int         ex, ey, est, elat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rf, input int mode, input bit ov, input bit v, input logic [1:0] r,
                       input int ex, input int ey, input int est, input int elat);
        vec_t e;
        e.rst_first = rf; e.mode = mode; e.ov = ov; e.v = v; e.r = r;
        e.ex = ex; e.ey = ey; e.est = est; e.elat = elat;
        tbl.push_back(e);
    endtask

    initial begin
        int m_x, m_y, m_st, m_pend, ev_dir, lat, d;
        bit v, ov, ev;
        logic [1:0] r, er;

        // Open map: three plain ticks, same-cycle request, over freeze, pend persistence.
        add(1, 0, 0, 0, 2'd0, 306, 224, 2, 4);
        add(0, 0, 0, 0, 2'd0, 308, 224, 2, 4);
        add(0, 0, 0, 0, 2'd0, 310, 224, 2, 4);
        add(0, 0, 0, 1, 2'd1, 310, 222, 1, 4);
        add(0, 0, 0, 1, 2'd0, 310, 224, 0, 4);
        add(0, 0, 1, 0, 2'd0, 310, 224, 0, 0);
        add(0, 0, 1, 1, 2'd3, 310, 224, 0, 0);
        add(0, 0, 0, 0, 2'd0, 308, 224, 3, 4);
        // Walls at x>=339 or y>=256: rejects and current-direction fallbacks.
        add(1, 1, 0, 0, 2'd0, 306, 224, 2, 4);
        add(0, 1, 0, 1, 2'd0, 306, 224, 2, 0);
        add(0, 1, 0, 1, 2'd1, 306, 222, 1, 4);
        add(0, 1, 0, 1, 2'd2, 306, 220, 1, 6);
        add(0, 1, 0, 0, 2'd0, 306, 218, 1, 6);
        add(0, 1, 0, 1, 2'd0, 306, 220, 0, 4);
        add(0, 1, 0, 1, 2'd2, 306, 222, 0, 6);
        add(0, 1, 0, 0, 2'd0, 306, 224, 0, 6);
        add(0, 1, 0, 0, 2'd0, 306, 224, 0, 0);

        do_reset();
        chk("rst_PacX", int'(x1), 304);
        chk("rst_PacY", int'(y1), 224);
        chk("rst_state", int'(st1), 2);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_moved", int'(moved1), 0);
        chk("rst_probe", int'(px1) + int'(py1), 0);

        foreach (tbl[i]) begin
            map_mode = tbl[i].mode;
            if (tbl[i].rst_first) do_reset();
            apply_tick(tbl[i].v, tbl[i].r, tbl[i].ov, 1'b0, 2'd0,
                       tbl[i].ex, tbl[i].ey, tbl[i].est, tbl[i].elat, 1'b0);
        end

        // Left edge with START_X=0: blocked request falls back to heading right.
        use0 = 1'b1; map_mode = 0;
        do_reset();
        apply_tick(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 2, 224, 2, 6, 1'b1);
        apply_tick(1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 0, 224, 3, 4, 1'b0);
        apply_tick(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 0, 224, 3, 0, 1'b1);
        apply_tick(1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2, 224, 2, 4, 1'b0);

        // Asynchronous reset while in REQ_B.
        use0 = 1'b0;
        do_reset();
        apply_tick(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 306, 224, 2, 4, 1'b0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk("busy_in_reqb", int'(busy1), 1);
        rst = 1'b1;
        #1;
        chk("async_PacX", int'(x1), 304);
        chk("async_state", int'(st1), 2);
        chk("async_busy", int'(busy1), 0);
        chk("async_probe", int'(px1) + int'(py1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply_tick(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 306, 224, 2, 4, 1'b0);

        // Randomized ticks on a scattered-wall map against the reference model.
        map_mode = 2;
        do_reset();
        m_x = 304; m_y = 224; m_st = 2; m_pend = 2;
        for (int n = 0; n < 150; n++) begin
            v  = 1'($urandom_range(0, 1));
            r  = 2'($urandom_range(0, 3));
            ov = ($urandom_range(0, 9) == 0);
            ev = ($urandom_range(0, 3) == 0);
            er = 2'($urandom_range(0, 3));
            ev_dir = v ? int'(r) : m_pend;
            if (v) m_pend = int'(r);
            lat = 0; d = -1;
            if (!ov) begin
                if (!blocked(2, m_x, m_y, ev_dir)) begin
                    lat = 4; d = ev_dir;
                end else if (!blocked(2, m_x, m_y, m_st)) begin
                    lat = 6; d = m_st;
                end
            end
            case (d)
                0:       m_y = m_y + 2;
                1:       m_y = m_y - 2;
                2:       m_x = m_x + 2;
                3:       m_x = m_x - 2;
                default: m_x = m_x;
            endcase
            if (d >= 0) m_st = d;
            if (ev) m_pend = int'(er);
            apply_tick(v, r, ov, ev, er, m_x, m_y, m_st, lat, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
